// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit controller: op encodings,
// default busy lengths and FSM state encoding.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // True for the ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: FSM with busy down-counter, operand-captured
// arithmetic result, architectural HI/LO registers, MFHI/MFLO read mux and
// the stall request seen by the pipeline hazard logic.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        d_is_mdu,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, r_lo;
    logic [31:0]        r_res_hi, r_res_lo;
    logic               r_res_vld;
    logic               w_load_mul, w_load_div, w_commit, w_mthi, w_mtlo;
    logic signed [63:0] w_rs_sx, w_rt_sx, w_prod_s;
    logic [63:0]        w_prod_u, w_prod, w_quot_rem;

    // Signed divide; the one overflowing case (-2^31 / -1) wraps to -2^31 rem 0.
    function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            q = sa;
            r = '0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    // Unsigned divide; a zero divisor yields zeros that are never committed.
    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    assign w_rs_sx  = {{32{rs_data[31]}}, rs_data};
    assign w_rt_sx  = {{32{rt_data[31]}}, rt_data};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Select product and quotient/remainder flavour from the issued op.
    always_comb begin
        w_prod     = (mdu_op == OP_MULT) ? w_prod_s : w_prod_u;
        w_quot_rem = (mdu_op == OP_DIV) ? div_s(rs_data, rt_data) : div_u(rs_data, rt_data);
    end

    // Next-state, counter and strobe decode; starts are only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_mul  = 1'b0;
        w_load_div  = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            w_load_mul  = 1'b1;
                            w_state_nxt = ST_MUL;
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV, OP_DIVU: begin
                            w_load_div  = 1'b1;
                            w_state_nxt = ST_DIV;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                        end
                        OP_MTHI: w_mthi = 1'b1;
                        OP_MTLO: w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and busy counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the result at start so later operand changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_hi  <= '0;
            r_res_lo  <= '0;
            r_res_vld <= 1'b0;
        end else if (w_load_mul) begin
            r_res_hi  <= w_prod[63:32];
            r_res_lo  <= w_prod[31:0];
            r_res_vld <= 1'b1;
        end else if (w_load_div) begin
            r_res_hi  <= w_quot_rem[63:32];
            r_res_lo  <= w_quot_rem[31:0];
            r_res_vld <= (rt_data != 32'd0);
        end
    end

    // HI/LO: moved-to directly in IDLE, or committed at the last busy edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_commit && r_res_vld) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
            if (w_mthi) r_hi <= rs_data;
            if (w_mtlo) r_lo <= rs_data;
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign stall_req = d_is_mdu & (busy | (start & is_long_op(mdu_op)));
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign rdata     = (mdu_op == OP_MFHI) ? r_hi :
                       (mdu_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} pushed at issue, popped
// and compared once busy drops.
module tb_mdu_ctrl;

    localparam logic [3:0] T_NONE = 4'd0, T_MULT = 4'd1, T_MULTU = 4'd2, T_DIV = 4'd3,
                           T_DIVU = 4'd4, T_MTHI = 4'd5, T_MTLO = 4'd6, T_MFHI = 4'd7,
                           T_MFLO = 4'd8;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int BOUND  = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        d_is_mdu = 1'b0;
    logic        busy, stall_req;
    logic [31:0] hi, lo, rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .rs_data(rs_data), .rt_data(rt_data), .d_is_mdu(d_is_mdu),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo), .rdata(rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    function automatic logic [63:0] model_res(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = cur;
        case (op)
            T_MULT:  begin p = sa * sb; res = p; end
            T_MULTU: res = ua * ub;
            T_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
            T_DIVU:  if (b != 0) begin
                         p = ua / ub; res[31:0] = p[31:0];
                         p = ua % ub; res[63:32] = p[31:0];
                     end
            default: ;
        endcase
        return res;
    endfunction

    // One-cycle start pulse; operands scrambled afterwards. Returns stall_req seen in the start cycle.
    task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic stall_s);
        @(posedge clk); #1;
        start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
        @(negedge clk);
        stall_s = stall_req;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = T_NONE; rs_data = $urandom; rt_data = $urandom;
    endtask

    // Count busy cycles until idle (bounded); optionally inject a start at busy cycle inject_at.
    task automatic wait_idle(input int inject_at, output int cycles, output int stall_lo);
        cycles = 0;
        stall_lo = 0;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (stall_req !== 1'b1) stall_lo++;
            if (cycles == inject_at) begin
                start = 1'b1; mdu_op = T_DIVU; rs_data = 32'd100; rt_data = 32'd7;
            end else begin
                start = 1'b0; mdu_op = T_NONE;
            end
        end
        start = 1'b0; mdu_op = T_NONE;
    endtask

    task automatic test_reset();
        d_is_mdu = 1'b1; mdu_op = T_MFHI;
        #12;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        // first edge after release must accept a start
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; mdu_op = T_MTLO; rs_data = 32'h5A5A_0001;
        @(posedge clk); #1;
        start = 1'b0; mdu_op = T_NONE; d_is_mdu = 1'b0;
        m_lo = 32'h5A5A_0001;
        n_tests++; if (lo !== m_lo) begin n_fail++; $display("FAIL first_start: got lo=%h expected %h", lo, m_lo); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_start_busy: got %b expected 0", busy); end
    endtask

    task automatic test_move();
        logic s;
        d_is_mdu = 1'b1;
        drive_start(T_MTHI, 32'h1234_5678, 32'hFFFF_0000, s);
        m_hi = 32'h1234_5678;
        n_tests++; if (s !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b expected 0", s); end
        n_tests++; if (hi !== m_hi || busy !== 1'b0) begin n_fail++; $display("FAIL mthi: got hi=%h busy=%b expected %h 0", hi, busy, m_hi); end
        drive_start(T_MTLO, 32'h9ABC_DEF0, 32'd0, s);
        m_lo = 32'h9ABC_DEF0;
        n_tests++; if (lo !== m_lo || hi !== m_hi) begin n_fail++; $display("FAIL mtlo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
        drive_start(T_MFHI, 32'h1111_1111, 32'd0, s);
        n_tests++; if ({hi, lo} !== {m_hi, m_lo} || busy !== 1'b0) begin n_fail++; $display("FAIL mfhi_start: got %h_%h busy=%b expected %h_%h", hi, lo, busy, m_hi, m_lo); end
        d_is_mdu = 1'b0;
        mdu_op = T_MFHI; #1;
        n_tests++; if (rdata !== m_hi) begin n_fail++; $display("FAIL rdata_mfhi: got %h expected %h", rdata, m_hi); end
        mdu_op = T_MFLO; #1;
        n_tests++; if (rdata !== m_lo) begin n_fail++; $display("FAIL rdata_mflo: got %h expected %h", rdata, m_lo); end
        mdu_op = T_MTHI; #1;
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rdata_other: got %h expected 0", rdata); end
        mdu_op = T_NONE;
    endtask

    // Issue one long op, check busy length, stall in start cycle and popped result.
    task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int exp_cyc);
        logic        s;
        int          cyc, sl;
        logic [63:0] e;
        sb_q.push_back(exp);
        drive_start(op, a, b, s);
        wait_idle(0, cyc, sl);
        n_tests++; if (s !== d_is_mdu) begin n_fail++; $display("FAIL %s_start_stall: got %b expected %b", name, s, d_is_mdu); end
        n_tests++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, cyc, exp_cyc); end
        if (d_is_mdu) begin
            n_tests++; if (sl != 0) begin n_fail++; $display("FAIL %s_busy_stall: got %0d low cycles expected 0", name, sl); end
        end
        e = sb_q.pop_front();
        n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL %s_result: got %h_%h expected %h_%h", name, hi, lo, e[63:32], e[31:0]); end
        {m_hi, m_lo} = e;
    endtask

    task automatic test_mult();
        run_long("mult_neg", T_MULT, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, MULT_N);
        run_long("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, MULT_N);
    endtask

    task automatic test_div();
        run_long("divu_7_2", T_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, DIV_N);
        run_long("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, DIV_N);
        run_long("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, DIV_N);
    endtask

    task automatic test_div_zero();
        logic s;
        drive_start(T_MTHI, 32'h12, 32'd0, s);
        drive_start(T_MTLO, 32'h34, 32'd0, s);
        run_long("div_zero", T_DIV, 32'd5, 32'd0, {32'h12, 32'h34}, DIV_N);
        run_long("divu_zero", T_DIVU, 32'hFFFF_FFFF, 32'd0, {32'h12, 32'h34}, DIV_N);
    endtask

    task automatic test_stall();
        logic [63:0] e;
        d_is_mdu = 1'b1;
        e = model_res(T_MULT, 32'h0001_0003, 32'h0002_0005, {m_hi, m_lo});
        run_long("mult_stall", T_MULT, 32'h0001_0003, 32'h0002_0005, e, MULT_N);
        #1;
        n_tests++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL stall_after: got %b expected 0", stall_req); end
        mdu_op = T_MFLO; #1;
        n_tests++; if (rdata !== e[31:0]) begin n_fail++; $display("FAIL stall_rdata: got %h expected %h", rdata, e[31:0]); end
        mdu_op = T_NONE; d_is_mdu = 1'b0;
    endtask

    task automatic test_ignore_start();
        logic s;
        int   cyc, sl;
        logic [63:0] e;
        sb_q.push_back({32'd0, 32'd12});
        drive_start(T_MULT, 32'd3, 32'd4, s);
        wait_idle(2, cyc, sl);
        n_tests++; if (cyc != MULT_N) begin n_fail++; $display("FAIL ignore_cycles: got %0d expected %0d", cyc, MULT_N); end
        e = sb_q.pop_front();
        n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL ignore_result: got %h_%h expected %h_%h", hi, lo, e[63:32], e[31:0]); end
        {m_hi, m_lo} = e;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || {hi, lo} !== e) begin n_fail++; $display("FAIL ignore_after: got busy=%b %h_%h expected 0 %h", busy, hi, lo, e); end
    endtask

    task automatic test_reset_mid();
        logic s;
        int   cnt, seen;
        drive_start(T_MTHI, 32'hDEAD_BEEF, 32'd0, s);
        drive_start(T_DIV, 32'd100, 32'd7, s);
        cnt = 1;
        for (int i = 0; i < BOUND && cnt < 4; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        reset = 1'b0; #1;
        n_tests++; if (cnt != 4) begin n_fail++; $display("FAIL rstmid_reach: got %0d expected 4", cnt); end
        n_tests++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin n_fail++; $display("FAIL rstmid_now: got busy=%b %h_%h expected 0 0", busy, hi, lo); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        repeat (DIV_N + 4) begin
            @(negedge clk);
            if (busy) seen++;
        end
        n_tests++; if (seen != 0 || {hi, lo} !== 64'd0) begin n_fail++; $display("FAIL rstmid_later: got busy=%0d %h_%h expected 0 0", seen, hi, lo); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_random_ops();
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            d_is_mdu = 1'(i % 2);
            run_long("random", op, a, b, model_res(op, a, b, {m_hi, m_lo}),
                     (op == T_MULT || op == T_MULTU) ? MULT_N : DIV_N);
        end
        d_is_mdu = 1'b0;
    endtask

    initial begin
        test_reset();
        test_move();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_random_ops();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse from E stage that issues the op on mdu_op.
REQ-006 mdu_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
REQ-007 rs_data  in  32  forwarded E-stage rs operand.
REQ-008 rt_data  in  32  forwarded E-stage rt operand.
REQ-009 d_is_mdu  in  1  instruction in D stage is any MDU op (1..8).
REQ-010 busy  out  1  multi-cycle operation in progress.
REQ-011 stall_req  out  1  request to freeze F/D and bubble E, ORed into the existing stall.
REQ-012 hi  out  32  architectural HI register.
REQ-013 lo  out  32  architectural LO register.
REQ-014 rdata  out  32  MFHI/MFLO read data for the E-stage result mux.

Function
REQ-015 FSM states: IDLE, MUL, DIV; a down-counter cnt holds the remaining busy cycles.
REQ-016 IDLE + start + op MULT/MULTU: latch product, load cnt=MULT_CYCLES, go MUL.
REQ-017 IDLE + start + op DIV/DIVU: latch quotient/remainder, load cnt=DIV_CYCLES, go DIV.
REQ-018 Start sampled at edge ending cycle T: busy=1 in cycles T+1..T+N; hi/lo update at edge ending T+N; busy=0 from T+N+1; state returns to IDLE.
REQ-019 MUL/DIV: cnt decrements each edge; commit and go IDLE when cnt==1.
REQ-020 MULT: signed 64-bit product, HI=[63:32], LO=[31:0]; MULTU same, unsigned.
REQ-021 DIV: signed, LO=quotient truncated toward zero, HI=remainder with sign of dividend; DIVU unsigned.
REQ-022 Divisor 0: run the full DIV_CYCLES busy period; HI and LO are left unchanged at commit.
REQ-023 MTHI/MTLO with start in IDLE: hi (or lo) <= rs_data at that edge; no busy cycle.
REQ-024 start while busy=1: ignored, with no state change.
REQ-025 start with op NONE/MFHI/MFLO: no state change.
REQ-026 rdata combinational: hi when mdu_op==MFHI, lo when MFLO, otherwise 0.
REQ-027 stall_req = d_is_mdu & (busy | (start & op in 1..4)); combinational.
REQ-028 Operands are captured at start; later changes on rs_data/rt_data do not affect the result.

Reset
REQ-029 reset low: state=IDLE, cnt=0, busy=0, hi=0, lo=0, latched result=0, asynchronously.
REQ-030 reset asserted mid-operation aborts the operation; no commit occurs.
REQ-031 First start is accepted at the first rising edge after reset deasserts.

Structure
REQ-032 mdu_op encodings, MULT_CYCLES/DIV_CYCLES defaults and the state encoding are defined in the shared constants file used by CTRL.
REQ-033 The block contains no sub-module; the FSM, counter, arithmetic and HI/LO registers are all in mdu_ctrl.
REQ-034 Instantiated in the E stage; CTRL decodes mdu_op and d_is_mdu; the top level ORs stall_req with the hazard stall.

Verification
REQ-035 Bench drives MULT rs=0xFFFFFFFF, rt=2 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-036 Bench drives DIVU rs=7, rt=2 -> busy high for exactly 10 cycles; then hi=1, lo=3. Bench repeats with DIV rs=-7, rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-037 Bench drives DIV by 0 with hi=0x12, lo=0x34 preloaded via MTHI/MTLO -> 10 busy cycles; then hi=0x12, lo=0x34.
REQ-038 Bench holds d_is_mdu=1 (MFLO in D) during a MULT -> stall_req high on the start cycle and for all 5 busy cycles; then rdata equals the new lo.
REQ-039 Bench issues a second start at busy cycle 2 of MULT 3*4 -> ignored; lo=12 at completion.
REQ-040 Bench pulls reset low at DIV busy cycle 4 -> busy=0 and hi=lo=0 immediately; no later commit.
